ej32_xu_sched: RTL
==================

// Module: ej32_xu_sched
// PURPOSE
//  Scheduler for the eJ32 extended arithmetic unit (mul, div, rem, shifts).
//  Round-robin arbitration between N_REQ requesters (core pipeline, debug/host).
//  Sequences a multi-cycle signed divider and returns each result with the requester id.
//  Sits between EJ32 control and the arithmetic datapath; drives stall via xu_bsy_o.
// PARAMETERS
//  DSZ    32  operand/result width (power of 2)
//  N_REQ  2   number of requesters (2..4)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset, asynchronous, active-high
//  req        in   N_REQ      request valid per requester, held until ack
//  req_op     in   N_REQ x 3  xu_op_t per requester
//  req_s      in   N_REQ x DSZ  NOS operand per requester
//  req_t      in   N_REQ x DSZ  TOS operand per requester
//  ack        out  N_REQ      one-hot, 1-cycle pulse: request accepted
//  rsp_vld    out  1          1-cycle pulse: result valid
//  rsp_id     out  2          requester index of rsp_t
//  rsp_t      out  DSZ        result (new TOS)
//  rsp_err    out  1          divide-by-zero flag (see CONFIGURATION)
//  xu_bsy_o   out  1          1 from accept until rsp_vld cycle inclusive
// BEHAVIOUR
//  Reset (async): state IDLE, ack=0, rsp_vld=0, rsp_id=0, rsp_t=0, rsp_err=0,
//   xu_bsy_o=0, rr pointer=0 (requester 0 has highest priority first).
//  FSM: IDLE -> EXEC (mul/shift) or DIV (idiv/irem) -> DONE -> IDLE.
//   IDLE: if any req, pick first set req at/after rr pointer; pulse ack, latch op/s/t/id;
//    rr pointer <= winner+1 mod N_REQ. Non-winners wait (no ack).
//   EXEC: 1 cycle compute; DONE next cycle.
//   DIV: radix-2 restoring on magnitudes, DSZ iterations, 1/cycle; then sign fixup.
//   DONE: rsp_vld=1 with rsp_t/rsp_id/rsp_err registered; return IDLE; a new accept
//    may occur in the cycle after DONE (no accept in DONE cycle).
//  Latency ack->rsp_vld: mul/shift 2 cycles; div/rem DSZ+2 cycles.
//  Ops: imul = low DSZ bits of s*t (signed); ishl = s << t[4:0];
//   ishr = arithmetic s >>> t[4:0]; iushr = logical s >> t[4:0] (5 bits for DSZ=32,
//   log2(DSZ) bits generally). Unknown op: rsp_t = t, rsp_err=0, EXEC latency.
//  Division (Java): quotient truncates toward zero; remainder has sign of s.
//   s=MIN, t=-1 -> q=MIN, r=0, no error.
//  Divide by zero: see CONFIGURATION.
//  Protocol: requester holds req/op/operands stable until ack; dropping early is
//   a violation (assertion in sim). Operands are latched at ack, may change after.
//  Reset mid-DIV: abort immediately, no rsp_vld, outputs to reset values.
//  Simultaneous req from all while busy: all wait; arbitration re-runs in IDLE.
// CONFIGURATION
//  XU_DIV0_TRAP_EN defined: t==0 on idiv/irem skips DIV; DONE next cycle with
//   rsp_t=0, rsp_err=1 (latency 2).
//  Not defined: rsp_err tied 0; divider runs normally giving q=all-ones (-1),
//   r=s, latency DSZ+2.
// STRUCTURE
//  ej32_pkg: xu_op_t enum {XU_MUL,XU_DIV,XU_REM,XU_SHL,XU_SHR,XU_USHR},
//   xu_st_t {IDLE,EXEC,DIV,DONE}, opcode->xu_op_t mapping function.
//  Sub-module xu_rr_arb: combinational round-robin pick + registered pointer.
//  Divider iteration counter and remainder/quotient shift regs inline.
// TESTING
//  1. req0 imul s=7 t=-6 -> ack0 next edge, rsp_vld 2 cycles later, rsp_t=-42, id=0.
//  2. req0 idiv s=-7 t=2 -> q=-3 after 34 cycles; irem same operands -> r=-1.
//  3. req0,req1 both held, irem s=100 t=7 -> ack0 first, then ack1; both rsp 2, id order 0,1.
//  4. ishr s=0x80000000 t=36 -> 0xF8000000; iushr same -> 0x08000000.
//  5. idiv s=0x80000000 t=-1 -> 0x80000000, rsp_err=0; t=0 -> per macro (0/err or -1).
//  6. rst asserted mid-DIV (cycle 10) -> outputs reset async, no rsp_vld, next req accepted.

Source files
------------

// File: rtl/ej32_xu_sched_pkg.sv
`default_nettype none
// ==========================================================================
// ej32_xu_sched_pkg : op/state encodings for the eJ32 extended arithmetic unit
// Rev 1.0
// ==========================================================================
package ej32_xu_sched_pkg;

  typedef enum logic [2:0] {
    XU_MUL  = 3'd0,
    XU_DIV  = 3'd1,
    XU_REM  = 3'd2,
    XU_SHL  = 3'd3,
    XU_SHR  = 3'd4,
    XU_USHR = 3'd5
  } xu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } xu_st_t;

  // Any encoding outside xu_op_t is executed as a pass-through of TOS
  localparam logic [2:0] XU_OP_BAD = 3'd7;

  function automatic logic [2:0] jvm_to_xu_op(input logic [7:0] opc);
    case (opc)
      8'h68:   return XU_MUL;
      8'h6c:   return XU_DIV;
      8'h70:   return XU_REM;
      8'h78:   return XU_SHL;
      8'h7a:   return XU_SHR;
      8'h7c:   return XU_USHR;
      default: return XU_OP_BAD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ej32_xu_sched_if.sv
`default_nettype none
// ==========================================================================
// ej32_xu_sched_if : requester <-> scheduler request/response bundle
// Rev 1.0
// ==========================================================================
interface ej32_xu_sched_if #(
  parameter int DSZ   = 32,
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]          req;
  logic [N_REQ-1:0][2:0]     req_op;
  logic [N_REQ-1:0][DSZ-1:0] req_s;
  logic [N_REQ-1:0][DSZ-1:0] req_t;
  logic [N_REQ-1:0]          ack;
  logic                      rsp_vld;
  logic [1:0]                rsp_id;
  logic [DSZ-1:0]            rsp_t;
  logic                      rsp_err;

  modport master (
    output req, req_op, req_s, req_t,
    input  ack, rsp_vld, rsp_id, rsp_t, rsp_err
  );

  modport slave (
    input  req, req_op, req_s, req_t,
    output ack, rsp_vld, rsp_id, rsp_t, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/ej32_xu_sched_rr_arb.sv
`default_nettype none
// ==========================================================================
// ej32_xu_sched_rr_arb : combinational round-robin pick, registered pointer
// Rev 1.0
// ==========================================================================
module ej32_xu_sched_rr_arb #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             adv_i,
  output logic             vld_o,
  output logic [1:0]       idx_o
);
  logic [1:0] ptr_q, ptr_d;

  // Scan from the highest offset down so the closest requester to ptr wins
  always_comb begin
    logic [1:0] cand;
    cand  = 2'd0;
    vld_o = 1'b0;
    idx_o = 2'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = 2'((int'(ptr_q) + k) % N_REQ);
      for (int i = 0; i < N_REQ; i++) begin
        if (req_i[i] && (cand == 2'(i))) begin
          vld_o = 1'b1;
          idx_o = cand;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) ptr_d = 2'((int'(idx_o) + 1) % N_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end
endmodule
`default_nettype wire

// File: rtl/ej32_xu_sched.sv
`default_nettype none
// ==========================================================================
// ej32_xu_sched : arbitrates requesters onto mul/shift (1 cycle) and a radix-2
// signed divider. Option macro XU_DIV0_TRAP_EN: t==0 div/rem -> 0 with rsp_err.
// Rev 1.0
// ==========================================================================
module ej32_xu_sched
  import ej32_xu_sched_pkg::*;
#(
  parameter int DSZ   = 32,
  parameter int N_REQ = 2
) (
  input  logic           clk,
  input  logic           rst,
  ej32_xu_sched_if.slave xu,
  output logic           xu_bsy_o
);
  localparam int c_SHW = $clog2(DSZ);
  localparam int c_CW  = $clog2(DSZ) + 1;
`ifdef XU_DIV0_TRAP_EN
  localparam bit c_TRAP_EN = 1'b1;
`else
  localparam bit c_TRAP_EN = 1'b0;
`endif

  xu_st_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [DSZ-1:0]   s_q, s_d, t_q, t_d;
  logic [DSZ-1:0]   dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d, res_q, res_d;
  logic [1:0]       id_q, id_d;
  logic [c_CW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d, vld_q, vld_d, bsy_q, bsy_d;
  logic [N_REQ-1:0] ack_q, ack_d;

  logic             w_arb_vld, w_acc, w_sel_div, w_op_div;
  logic [1:0]       w_idx;
  logic [2:0]       w_sel_op;
  logic [DSZ-1:0]   w_sel_s, w_sel_t, w_abs_s, w_abs_t, w_alu, w_q, w_r;
  logic [DSZ:0]     w_tmp, w_diff;
  logic [c_SHW-1:0] w_sh;

  assign w_acc = (state_q == IDLE) && w_arb_vld;

  ej32_xu_sched_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (xu.req),
    .adv_i (w_acc),
    .vld_o (w_arb_vld),
    .idx_o (w_idx)
  );

  always_comb begin
    w_sel_op = '0;
    w_sel_s  = '0;
    w_sel_t  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == 2'(i)) begin
        w_sel_op = xu.req_op[i];
        w_sel_s  = xu.req_s[i];
        w_sel_t  = xu.req_t[i];
      end
    end
  end

  assign w_sel_div = (w_sel_op == XU_DIV) || (w_sel_op == XU_REM);
  assign w_op_div  = (op_q == XU_DIV) || (op_q == XU_REM);
  assign w_abs_s   = w_sel_s[DSZ-1] ? -w_sel_s : w_sel_s;
  assign w_abs_t   = w_sel_t[DSZ-1] ? -w_sel_t : w_sel_t;
  assign w_sh      = t_q[c_SHW-1:0];

  // Restoring step: dividend bits shift out of quo_q while quotient bits shift in
  assign w_tmp  = {rem_q, quo_q[DSZ-1]};
  assign w_diff = w_tmp - {1'b0, dvs_q};

  always_comb begin
    w_alu = t_q;
    case (op_q)
      XU_MUL:  w_alu = s_q * t_q;
      XU_SHL:  w_alu = s_q << w_sh;
      XU_SHR:  w_alu = $signed(s_q) >>> w_sh;
      XU_USHR: w_alu = s_q >> w_sh;
      XU_DIV,
      XU_REM:  w_alu = '0;
      default: ;
    endcase
  end

  // Java semantics: quotient truncates toward zero, remainder follows dividend
  always_comb begin
    w_q = (s_q[DSZ-1] ^ t_q[DSZ-1]) ? -quo_q : quo_q;
    w_r = s_q[DSZ-1] ? -rem_q : rem_q;
    if (dvs_q == '0) begin
      w_q = '1;
      w_r = s_q;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    s_d     = s_q;
    t_d     = t_q;
    id_d    = id_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    ack_d   = '0;
    vld_d   = 1'b0;
    bsy_d   = bsy_q & ~vld_q;
    case (state_q)
      IDLE: begin
        if (w_arb_vld) begin
          for (int i = 0; i < N_REQ; i++) ack_d[i] = (w_idx == 2'(i));
          op_d  = w_sel_op;
          s_d   = w_sel_s;
          t_d   = w_sel_t;
          id_d  = w_idx;
          quo_d = w_abs_s;
          dvs_d = w_abs_t;
          rem_d = '0;
          cnt_d = '0;
          bsy_d = 1'b1;
          if (w_sel_div && !(c_TRAP_EN && (w_sel_t == '0))) state_d = DIV;
          else                                             state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = w_alu;
        err_d   = c_TRAP_EN & w_op_div;
        state_d = DONE;
      end
      DIV: begin
        if (cnt_q == c_CW'(DSZ)) begin
          res_d   = (op_q == XU_DIV) ? w_q : w_r;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + c_CW'(1);
          if (!w_diff[DSZ]) begin
            rem_d = w_diff[DSZ-1:0];
            quo_d = {quo_q[DSZ-2:0], 1'b1};
          end else begin
            rem_d = w_tmp[DSZ-1:0];
            quo_d = {quo_q[DSZ-2:0], 1'b0};
          end
        end
      end
      DONE: begin
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      s_q     <= '0;
      t_q     <= '0;
      id_q    <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      ack_q   <= '0;
      vld_q   <= 1'b0;
      bsy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      s_q     <= s_d;
      t_q     <= t_d;
      id_q    <= id_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      vld_q   <= vld_d;
      bsy_q   <= bsy_d;
    end
  end

  assign xu.ack     = ack_q;
  assign xu.rsp_vld = vld_q;
  assign xu.rsp_id  = id_q;
  assign xu.rsp_t   = res_q;
  assign xu.rsp_err = err_q;
  assign xu_bsy_o   = bsy_q;

  // A pending request must stay up until its ack is seen
  for (genvar i = 0; i < N_REQ; i++) begin : g_req_hold
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      ($past(xu.req[i]) && !$past(xu.ack[i]) && !xu.ack[i]) |-> xu.req[i]);
  end
endmodule
`default_nettype wire
